// File: rtl/reg_file_param.sv
// reg_file_param
//   Two-read / one-write register file with registered read ports,
//   write-first bypass, optional hardwired-zero entry 0 and a background
//   clear engine that sweeps every entry to zero over DEPTH cycles.
//
//   Optional feature macro: RF_PARITY_EN
//     defined   : each entry carries an even-parity bit; valid non-bypass
//                 reads recheck it and set the sticky par_err flag.
//     undefined : no parity storage, par_err is tied to 0.
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     rd_en_n, rd_addr_n    read request / address, ports 1 and 2
//     rd_data_n, rd_valid_n registered read data and valid, ports 1 and 2
//     wr_en, wr_addr, wr_data  write port (accepted only when IDLE)
//     clr_start             pulse to start a clear sweep
//     busy                  sweep in progress (CLEAR or DONE)
//     clr_done              one-cycle pulse at end of sweep
//     par_err               sticky parity error flag
//
//   Clear FSM
//     state   | meaning
//     --------+--------------------------------------------------
//     S_IDLE  | normal read/write operation
//     S_CLEAR | mem[cnt] <= 0 each cycle, cnt runs 0 .. DEPTH-1
//     S_DONE  | clr_done pulse, returns to S_IDLE next cycle

module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_1,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic [DATA_W-1:0] rd_data_1,
    output logic              rd_valid_1,
    input  logic              rd_en_2,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_valid_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done,
    output logic              par_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;
    logic              clr_done_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] rd_data_1_q, rd_data_1_d;
    logic [DATA_W-1:0] rd_data_2_q, rd_data_2_d;
    logic              rd_valid_1_q, rd_valid_1_d;
    logic              rd_valid_2_q, rd_valid_2_d;

    logic idle;
    logic wr_accept;
    logic zero_1, zero_2;
    logic byp_1, byp_2;

    assign idle      = (state_q == S_IDLE);
    // Discarded zero-register writes are not accepted, so they neither
    // update storage nor bypass onto a read port.
    assign wr_accept = wr_en && idle && !((ZERO_REG != 0) && (wr_addr == '0));
    assign zero_1    = (ZERO_REG != 0) && (rd_addr_1 == '0);
    assign zero_2    = (ZERO_REG != 0) && (rd_addr_2 == '0);
    assign byp_1     = wr_accept && (wr_addr == rd_addr_1);
    assign byp_2     = wr_accept && (wr_addr == rd_addr_2);

    always_comb begin
        rd_valid_1_d = rd_en_1 && idle;
        rd_data_1_d  = '0;
        if (rd_valid_1_d && !zero_1) begin
            rd_data_1_d = byp_1 ? wr_data : mem_q[rd_addr_1];
        end
    end

    always_comb begin
        rd_valid_2_d = rd_en_2 && idle;
        rd_data_2_d  = '0;
        if (rd_valid_2_d && !zero_2) begin
            rd_data_2_d = byp_2 ? wr_data : mem_q[rd_addr_2];
        end
    end

    // Clear FSM with registered busy / done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    clr_done_q <= 1'b0;
                    if (clr_start) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q    <= S_DONE;
                        clr_done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    clr_done_q <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (state_q == S_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_accept) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_1_q  <= '0;
            rd_data_2_q  <= '0;
            rd_valid_1_q <= 1'b0;
            rd_valid_2_q <= 1'b0;
        end else begin
            rd_data_1_q  <= rd_data_1_d;
            rd_data_2_q  <= rd_data_2_d;
            rd_valid_1_q <= rd_valid_1_d;
            rd_valid_2_q <= rd_valid_2_d;
        end
    end

`ifdef RF_PARITY_EN
    logic par_mem_q [DEPTH];
    logic par_err_q;
    logic err_1, err_2;

    // Only reads served from storage are checked; bypassed data never
    // touched the array and entry 0 of a zero register is not stored.
    assign err_1 = rd_valid_1_d && !zero_1 && !byp_1 &&
                   (par_mem_q[rd_addr_1] != ^mem_q[rd_addr_1]);
    assign err_2 = rd_valid_2_d && !zero_2 && !byp_2 &&
                   (par_mem_q[rd_addr_2] != ^mem_q[rd_addr_2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) par_mem_q[i] <= 1'b0;
        end else if (state_q == S_CLEAR) begin
            par_mem_q[cnt_q] <= 1'b0;
        end else if (wr_accept) begin
            par_mem_q[wr_addr] <= ^wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if (err_1 || err_2) begin
            par_err_q <= 1'b1;
        end else if (clr_start && idle) begin
            par_err_q <= 1'b0;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign rd_data_1  = rd_data_1_q;
    assign rd_data_2  = rd_data_2_q;
    assign rd_valid_1 = rd_valid_1_q;
    assign rd_valid_2 = rd_valid_2_q;
    assign busy       = busy_q;
    assign clr_done   = clr_done_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param (DATA_W=32, ADDR_W=5, ZERO_REG=1).
module tb_reg_file_param;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en_1, rd_en_2, wr_en, clr_start;
    logic [AW-1:0] rd_addr_1, rd_addr_2, wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data_1, rd_data_2;
    logic          rd_valid_1, rd_valid_2, busy, clr_done, par_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .rd_en_1(rd_en_1), .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1), .rd_valid_1(rd_valid_1),
        .rd_en_2(rd_en_2), .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2), .rd_valid_2(rd_valid_2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_start(clr_start), .busy(busy), .clr_done(clr_done), .par_err(par_err)
    );

    typedef struct {
        logic          re1;
        logic [AW-1:0] ra1;
        logic          re2;
        logic [AW-1:0] ra2;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] d1;
        logic          v1;
        logic [DW-1:0] d2;
        logic          v2;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rd_en_1 = 1'b0; rd_addr_1 = '0;
        rd_en_2 = 1'b0; rd_addr_2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        clr_start = 1'b0;
    endtask

    task automatic read_both(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                             input logic [DW-1:0] e1, input logic [DW-1:0] e2, input string tag);
        clear_inputs();
        rd_en_1 = 1'b1; rd_addr_1 = a1;
        rd_en_2 = 1'b1; rd_addr_2 = a2;
        tick();
        chk({tag, "_d1"}, rd_data_1, e1);
        chk({tag, "_v1"}, {31'b0, rd_valid_1}, 32'd1);
        chk({tag, "_d2"}, rd_data_2, e2);
        chk({tag, "_v2"}, {31'b0, rd_valid_2}, 32'd1);
        clear_inputs();
    endtask

    // Waits (bounded) for the sweep to finish, counting busy cycles and
    // clr_done pulses. Optionally injects a write+read or a second
    // clr_start at a given busy cycle.
    task automatic run_sweep(input int wr_at, input int restart_at,
                             output int busy_cycles, output int done_cnt);
        busy_cycles = 0;
        done_cnt    = 0;
        while (busy && busy_cycles < 200) begin
            busy_cycles++;
            if (clr_done) done_cnt++;
            clear_inputs();
            if (busy_cycles == wr_at) begin
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h5555_5555;
                rd_en_1 = 1'b1; rd_addr_1 = 5'd3;
            end
            if (busy_cycles == restart_at) clr_start = 1'b1;
            tick();
            if (busy_cycles == wr_at) begin
                chk("busy_rd_v1", {31'b0, rd_valid_1}, 32'd0);
                chk("busy_rd_d1", rd_data_1, 32'd0);
            end
        end
        clear_inputs();
        if (busy_cycles >= 200) chk("sweep_timeout", 32'(busy_cycles), 32'd33);
    endtask

    initial begin
        int bc, dc;

        vt[0]  = '{1'b1, 5'd0,  1'b1, 5'd31, 1'b0, 5'd0,  32'h0,         32'h0,         1'b1, 32'h0,         1'b1};
        vt[1]  = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd1,  32'hF0F0_F0F0, 32'h0,         1'b0, 32'h0,         1'b0};
        vt[2]  = '{1'b1, 5'd1,  1'b1, 5'd2,  1'b0, 5'd0,  32'h0,         32'hF0F0_F0F0, 1'b1, 32'h0,         1'b1};
        vt[3]  = '{1'b0, 5'd1,  1'b0, 5'd2,  1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 32'h0,         1'b0};
        vt[4]  = '{1'b1, 5'd1,  1'b1, 5'd31, 1'b1, 5'd31, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0F0F_0F0F, 1'b1};
        vt[5]  = '{1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  32'hDEAD_BEEF, 32'h0,         1'b1, 32'h0,         1'b1};
        vt[6]  = '{1'b1, 5'd0,  1'b1, 5'd31, 1'b0, 5'd0,  32'h0,         32'h0,         1'b1, 32'h0F0F_0F0F, 1'b1};
        vt[7]  = '{1'b1, 5'd7,  1'b1, 5'd7,  1'b1, 5'd7,  32'h1234_5678, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1};
        vt[8]  = '{1'b1, 5'd7,  1'b1, 5'd1,  1'b0, 5'd0,  32'h0,         32'h1234_5678, 1'b1, 32'hF0F0_F0F0, 1'b1};
        vt[9]  = '{1'b1, 5'd1,  1'b1, 5'd7,  1'b1, 5'd7,  32'hCAFE_F00D, 32'hF0F0_F0F0, 1'b1, 32'hCAFE_F00D, 1'b1};
        vt[10] = '{1'b1, 5'd7,  1'b0, 5'd7,  1'b0, 5'd0,  32'h0,         32'hCAFE_F00D, 1'b1, 32'h0,         1'b0};

        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_d1", rd_data_1, 32'd0);
        chk("rst_v1", {31'b0, rd_valid_1}, 32'd0);
        chk("rst_v2", {31'b0, rd_valid_2}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, clr_done}, 32'd0);
        chk("rst_par", {31'b0, par_err}, 32'd0);
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) read_both(a[AW-1:0], 5'(31 - a), 32'd0, 32'd0, "rst_rd");

        for (int i = 0; i < 11; i++) begin
            clear_inputs();
            rd_en_1 = vt[i].re1; rd_addr_1 = vt[i].ra1;
            rd_en_2 = vt[i].re2; rd_addr_2 = vt[i].ra2;
            wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            tick();
            chk($sformatf("vec%0d_d1", i), rd_data_1, vt[i].d1);
            chk($sformatf("vec%0d_v1", i), {31'b0, rd_valid_1}, {31'b0, vt[i].v1});
            chk($sformatf("vec%0d_d2", i), rd_data_2, vt[i].d2);
            chk($sformatf("vec%0d_v2", i), {31'b0, rd_valid_2}, {31'b0, vt[i].v2});
        end
        clear_inputs();

        // Fill everything, then sweep with a dropped mid-sweep write.
        for (int a = 0; a < DEPTH; a++) begin
            wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = 32'hA5A5_A5A5;
            tick();
        end
        read_both(5'd0, 5'd17, 32'd0, 32'hA5A5_A5A5, "fill_rd");

        clr_start = 1'b1;
        tick();
        clear_inputs();
        chk("sweep_busy_start", {31'b0, busy}, 32'd1);
        run_sweep(5, 0, bc, dc);
        chk("sweep_busy_cycles", 32'(bc), 32'd33);
        chk("sweep_done_pulses", 32'(dc), 32'd1);
        chk("sweep_done_low", {31'b0, clr_done}, 32'd0);
        for (int a = 0; a < DEPTH; a++) read_both(a[AW-1:0], 5'(31 - a), 32'd0, 32'd0, "swept_rd");

        // Reset mid-sweep: entry 25 is past the sweep pointer, so only
        // reset can zero it.
        wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h9999_9999;
        tick();
        clear_inputs();
        clr_start = 1'b1;
        tick();
        clear_inputs();
        bc = 0;
        while (busy && bc < 10) begin
            bc++;
            if (bc < 10) tick();
        end
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        rd_en_1 = 1'b1; rd_addr_1 = 5'd25;
        tick();
        rst = 1'b0;
        clear_inputs();
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, clr_done}, 32'd0);
        chk("midrst_v1", {31'b0, rd_valid_1}, 32'd0);
        read_both(5'd25, 5'd12, 32'd0, 32'd0, "midrst_rd");

        // New sweep is accepted; same-cycle write is performed then
        // cleared; a second clr_start while busy is ignored.
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h7777_7777;
        clr_start = 1'b1;
        tick();
        clear_inputs();
        chk("restart_busy", {31'b0, busy}, 32'd1);
        run_sweep(0, 3, bc, dc);
        chk("restart_busy_cycles", 32'(bc), 32'd33);
        chk("restart_done_pulses", 32'(dc), 32'd1);
        read_both(5'd12, 5'd3, 32'd0, 32'd0, "restart_rd");
        tick();
        chk("restart_stays_idle", {31'b0, busy}, 32'd0);

`ifdef RF_PARITY_EN
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_00FF;
        tick();
        clear_inputs();
        chk("par_clean", {31'b0, par_err}, 32'd0);
        dut.mem_q[5] = dut.mem_q[5] ^ 32'h0000_0100;
        rd_en_1 = 1'b1; rd_addr_1 = 5'd5;
        tick();
        clear_inputs();
        chk("par_set", {31'b0, par_err}, 32'd1);
        tick();
        chk("par_sticky", {31'b0, par_err}, 32'd1);
        clr_start = 1'b1;
        tick();
        clear_inputs();
        chk("par_cleared", {31'b0, par_err}, 32'd0);
        run_sweep(0, 0, bc, dc);
        chk("par_sweep_cycles", 32'(bc), 32'd33);
`else
        chk("par_tied", {31'b0, par_err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
